tile_fetch_arb: RTL and testbench

TILE_FETCH_ARB -- requirements
Module: tile_fetch_arb

---
 rtl/tile_fetch_pkg.sv | 11 +
 rtl/tile_fetch_arb_pipe_dly.sv | 46 ++++
 rtl/tile_fetch_arb.sv | 93 +++++++++
 tb/tb_tile_fetch_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tile_fetch_pkg.sv
// tile_fetch_pkg: board geometry, bus widths and game-logic FSM states for tile_fetch_arb.
package tile_fetch_pkg;
    localparam int TILE_LOG2 = 4;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int MAP_AW = 9;
    localparam int ROM_AW = 14;
    localparam int RGB_W = 12;
    localparam logic [RGB_W-1:0] GRID_RGB = 12'h444;
    typedef enum logic [1:0] {IDLE, GRANT, RDATA} gl_state_t;
endpackage

// File: rtl/tile_fetch_arb_pipe_dly.sv
// tfc_pipe_dly: aligns pixel valid/in-window (4 cycles) and tile-local px/py (2 cycles); TILE_FETCH_GRID_EN adds a grid flag.
module tfc_pipe_dly import tile_fetch_pkg::*; (
    input  logic                 clk_27,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic                 win,
    input  logic [TILE_LOG2-1:0] px,
    input  logic [TILE_LOG2-1:0] py,
    output logic [TILE_LOG2-1:0] px_d2,
    output logic [TILE_LOG2-1:0] py_d2,
    output logic                 valid_d4,
`ifdef TILE_FETCH_GRID_EN
    output logic                 grid_d4,
`endif
    output logic                 win_d4
);
    logic [3:0] v_sr, w_sr;
    logic [TILE_LOG2-1:0] px_d1, py_d1;
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            w_sr <= '0;
            px_d1 <= '0;
            py_d1 <= '0;
            px_d2 <= '0;
            py_d2 <= '0;
        end else begin
            v_sr <= {v_sr[2:0], valid};
            w_sr <= {w_sr[2:0], win};
            px_d1 <= px;
            py_d1 <= py;
            px_d2 <= px_d1;
            py_d2 <= py_d1;
        end
    end
`ifdef TILE_FETCH_GRID_EN
    logic [1:0] g_sr;
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) g_sr <= '0;
        else g_sr <= {g_sr[0], px_d2 == '0 || py_d2 == '0};
    end
    assign grid_d4 = g_sr[1];
`endif
    assign valid_d4 = v_sr[3];
    assign win_d4 = w_sr[3];
endmodule

// File: rtl/tile_fetch_arb.sv
// tile_fetch_arb: 4-cycle tile-map pixel fetch with video-priority map port sharing; TILE_FETCH_GRID_EN draws tile grid lines.
module tile_fetch_arb import tile_fetch_pkg::*; #(
    parameter int               BOARD_X0 = 200,
    parameter int               BOARD_Y0 = 80,
    parameter logic [RGB_W-1:0] BG_RGB   = 12'h000,
    parameter logic [1:0]       ROM_BANK = 2'b00
) (
    input  logic              clk_27,
    input  logic              rst_n,
    input  logic              vid_valid,
    input  logic [11:0]       vid_x,
    input  logic [11:0]       vid_y,
    output logic [MAP_AW-1:0] map_addr,
    output logic              map_we,
    output logic [3:0]        map_wdata,
    input  logic [3:0]        map_rdata,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [RGB_W-1:0]  rgb_rdata,
    output logic              pix_valid,
    output logic [RGB_W-1:0]  pix_rgb,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [MAP_AW-1:0] gl_addr,
    input  logic [3:0]        gl_wdata,
    output logic              gl_gnt,
    output logic              gl_rvalid,
    output logic [3:0]        gl_rdata
);
    localparam int TILE_PX = 1 << TILE_LOG2;
    gl_state_t state;
    logic [7:0] dx;
    logic [8:0] dy;
    logic in_win, vid_hit, valid_d4, win_d4;
    logic [TILE_LOG2-1:0] px_d2, py_d2;
    logic [RGB_W-1:0] tile_rgb;
    assign in_win = vid_x >= 12'(BOARD_X0) && vid_x < 12'(BOARD_X0 + BOARD_COLS * TILE_PX) &&
                    vid_y >= 12'(BOARD_Y0) && vid_y < 12'(BOARD_Y0 + BOARD_ROWS * TILE_PX);
    assign vid_hit = vid_valid && in_win;
    assign dx = vid_x[7:0] - 8'(BOARD_X0);
    assign dy = vid_y[8:0] - 9'(BOARD_Y0);
`ifdef TILE_FETCH_GRID_EN
    logic grid_d4;
    tfc_pipe_dly u_dly (
        .clk_27(clk_27), .rst_n(rst_n), .valid(vid_valid), .win(in_win),
        .px(dx[3:0]), .py(dy[3:0]), .px_d2(px_d2), .py_d2(py_d2),
        .valid_d4(valid_d4), .grid_d4(grid_d4), .win_d4(win_d4)
    );
    assign tile_rgb = grid_d4 ? GRID_RGB : rgb_rdata;
`else
    tfc_pipe_dly u_dly (
        .clk_27(clk_27), .rst_n(rst_n), .valid(vid_valid), .win(in_win),
        .px(dx[3:0]), .py(dy[3:0]), .px_d2(px_d2), .py_d2(py_d2),
        .valid_d4(valid_d4), .win_d4(win_d4)
    );
    assign tile_rgb = rgb_rdata;
`endif
    // A game access may only start when the slot it would occupy next cycle is not claimed by video.
    always_ff @(posedge clk_27 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            map_addr <= '0;
            map_we <= 1'b0;
            map_wdata <= '0;
            gl_gnt <= 1'b0;
            gl_rvalid <= 1'b0;
            rom_addr <= '0;
        end else begin
            map_we <= 1'b0;
            map_wdata <= '0;
            gl_gnt <= 1'b0;
            gl_rvalid <= 1'b0;
            rom_addr <= {ROM_BANK, map_rdata, py_d2, px_d2};
            if (vid_hit) map_addr <= {dy[8:4], dx[7:4]};
            case (state)
                IDLE: if (gl_req && !vid_hit) begin
                    state <= GRANT;
                    gl_gnt <= 1'b1;
                    map_addr <= gl_addr;
                    map_we <= gl_we;
                    map_wdata <= gl_wdata;
                end
                GRANT: begin
                    state <= map_we ? IDLE : RDATA;
                    gl_rvalid <= !map_we;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign pix_valid = valid_d4;
    assign pix_rgb = !valid_d4 ? '0 : win_d4 ? tile_rgb : BG_RGB;
    assign gl_rdata = gl_rvalid ? map_rdata : '0;
endmodule

// File: tb/tb_tile_fetch_arb.sv
// tb_tile_fetch_arb: directed and randomized checks of tile_fetch_arb against a pixel/port-sharing reference model.
module tb_tile_fetch_arb;
    logic clk_27 = 1'b0, rst_n = 1'b0, vid_valid = 1'b0;
    logic [11:0] vid_x = '0, vid_y = '0;
    logic [8:0] map_addr;
    logic map_we;
    logic [3:0] map_wdata;
    logic [3:0] map_rdata = '0;
    logic [13:0] rom_addr;
    logic [11:0] rgb_rdata = '0;
    logic pix_valid;
    logic [11:0] pix_rgb;
    logic gl_req = 1'b0, gl_we = 1'b0;
    logic [8:0] gl_addr = '0;
    logic [3:0] gl_wdata = '0;
    logic gl_gnt, gl_rvalid;
    logic [3:0] gl_rdata;

    tile_fetch_arb dut (
        .clk_27(clk_27), .rst_n(rst_n), .vid_valid(vid_valid), .vid_x(vid_x), .vid_y(vid_y),
        .map_addr(map_addr), .map_we(map_we), .map_wdata(map_wdata), .map_rdata(map_rdata),
        .rom_addr(rom_addr), .rgb_rdata(rgb_rdata), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_gnt(gl_gnt), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata)
    );

    always #5 clk_27 = ~clk_27;

    // Tile map RAM and tile ROM, each with one cycle of read latency.
    logic [3:0] mem [512];
    logic seeded = 1'b0;
    always @(posedge clk_27) begin
        if (!seeded) begin
            for (int i = 0; i < 512; i++) mem[i] <= (i == 0) ? 4'h3 : 4'($urandom);
            seeded <= 1'b1;
        end else if (map_we) mem[map_addr] <= map_wdata;
        map_rdata <= mem[map_addr];
    end

    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        logic [13:0] t;
        t = a * 14'd5 + 14'h123;
        return t[11:0];
    endfunction

    always @(posedge clk_27) rgb_rdata <= rom_fn(rom_addr);

    typedef struct {logic v; logic [11:0] rgb;} exp_t;
    exp_t pq[$];
    int n_chk = 0, n_fail = 0;
    logic exp_gnt = 1'b0, exp_rvalid = 1'b0;
    logic [3:0] exp_rd = '0, last_rd = '0;
    logic req_go = 1'b0, req_we = 1'b0;
    logic [8:0] req_addr = '0;
    logic [3:0] req_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input int x, input int y);
        return x >= 200 && x < 360 && y >= 80 && y < 400;
    endfunction

    function automatic exp_t pix_exp(input logic v, input int x, input int y);
        exp_t e;
        int px, py, a;
        e.v = v;
        e.rgb = 12'h000;
        if (v && in_win(x, y)) begin
            px = (x - 200) % 16;
            py = (y - 80) % 16;
            a = ((y - 80) / 16) * 16 + (x - 200) / 16;
            e.rgb = rom_fn(14'(int'(mem[a]) * 256 + py * 16 + px));
`ifdef TILE_FETCH_GRID_EN
            if (px == 0 || py == 0) e.rgb = 12'h444;
`endif
        end
        return e;
    endfunction

    // One pixel slot: check what the model says is due now, then present the next inputs.
    task automatic cycle(input logic v, input int x, input int y);
        exp_t e;
        logic hit, nxt_rvalid;
        @(negedge clk_27);
        e = pq.pop_front();
        chk("pix_valid", pix_valid, e.v);
        if (e.v) chk("pix_rgb", pix_rgb, e.rgb);
        chk("gl_gnt", gl_gnt, exp_gnt);
        chk("gl_rvalid", gl_rvalid, exp_rvalid);
        chk("map_we", map_we, exp_gnt && gl_we);
        if (exp_rvalid) begin
            chk("gl_rdata", gl_rdata, exp_rd);
            last_rd = gl_rdata;
        end
        if (exp_gnt) begin
            chk("gl_map_addr", map_addr, gl_addr);
            if (gl_we) chk("map_wdata", map_wdata, gl_wdata);
            exp_rd = mem[gl_addr];
            gl_req = 1'b0;
        end
        nxt_rvalid = exp_gnt && !gl_we;
        hit = v && in_win(x, y);
        vid_valid = v;
        vid_x = 12'(x);
        vid_y = 12'(y);
        if (req_go) begin
            gl_req = 1'b1;
            gl_we = req_we;
            gl_addr = req_addr;
            gl_wdata = req_wdata;
            req_go = 1'b0;
        end
        exp_gnt = gl_req && !hit && !exp_gnt && !exp_rvalid;
        exp_rvalid = nxt_rvalid;
        pq.push_back(pix_exp(v, x, y));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_rgb", pix_rgb, 0);
        chk("rst_map_we", map_we, 0);
        chk("rst_map_addr", map_addr, 0);
        chk("rst_map_wdata", map_wdata, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_gl_gnt", gl_gnt, 0);
        chk("rst_gl_rvalid", gl_rvalid, 0);
        chk("rst_gl_rdata", gl_rdata, 0);
        vid_valid = 1'b0;
        gl_req = 1'b0;
        req_go = 1'b0;
        exp_gnt = 1'b0;
        exp_rvalid = 1'b0;
        pq.delete();
        repeat (4) pq.push_back('{v: 1'b0, rgb: 12'h000});
        @(negedge clk_27);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk_27);
        do_reset();
        cycle(1, 200, 80);
        cycle(0, 0, 0);
        chk("map_addr_origin", map_addr, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("rom_addr_origin", rom_addr, 14'h0300);
        cycle(0, 0, 0);
        cycle(1, 359, 399);
        cycle(1, 360, 80);
        chk("map_addr_corner", map_addr, {5'd19, 4'd9});
        cycle(1, 216, 96);
        cycle(0, 0, 0);
        chk("rom_addr_corner_lo", rom_addr[7:0], 8'hFF);
        repeat (4) cycle(0, 0, 0);
        req_go = 1'b1; req_we = 1'b1; req_addr = 9'h015; req_wdata = 4'hA;
        repeat (4) cycle(0, 0, 0);
        req_go = 1'b1; req_we = 1'b0; req_addr = 9'h015;
        repeat (3) cycle(0, 0, 0);
        chk("write_readback", last_rd, 4'hA);
        req_go = 1'b1; req_we = 1'b0; req_addr = 9'h0AB;
        for (int i = 0; i < 50; i++) cycle(1, 200 + i * 3, 100 + i);
        repeat (4) cycle(0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (!gl_req && !req_go && !exp_gnt && !exp_rvalid && $urandom_range(0, 9) == 0) begin
                req_go = 1'b1;
                req_we = 1'b0;
                req_addr = 9'($urandom);
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(180, 380), $urandom_range(60, 420));
        end
        repeat (6) cycle(0, 0, 0);
        cycle(1, 250, 150);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        do_reset();
        repeat (6) cycle(0, 0, 0);
        req_go = 1'b1; req_we = 1'b0; req_addr = 9'h020;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0);
            if (gl_gnt) break;
        end
        chk("grant_before_reset", gl_gnt, 1);
        do_reset();
        repeat (5) cycle(0, 0, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
